demux4s_stream: RTL and testbench
=================================

// Module: demux4s_stream
// PURPOSE
//  1-to-4 stream demultiplexer; the distribution-side counterpart of the 4:1 select mux.
//  Each input word carries a 2-bit destination select and is steered into one of four
//  single-entry output holding registers, each with its own valid/ready handshake.
//  A busy output stalls only words addressed to it. Each output counts delivered words.
// PARAMETERS
//  W      4  data width of in_data and each out_data*
//  CNT_W  8  width of each per-output delivered-word counter
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous reset, active-low
//  in_data    in   W      input word
//  in_sel     in   2      destination select: 0..3 -> output 0..3
//  in_valid   in   1      in_data/in_sel valid
//  in_ready   out  1      block accepts word this cycle (combinational)
//  out_data0  out  W      output 0 word (out_data1..3 identical, outputs 1..3)
//  out_valid  out  4      bit k: output k holds a word
//  out_ready  in   4      bit k: consumer k takes word this cycle
//  out_cnt0   out  CNT_W  words delivered on output 0 (out_cnt1..3 likewise)
// BEHAVIOUR
//  - Reset (rst_n=0, async): out_valid=4'b0, all out_data*=0, all out_cnt*=0.
//    Reset mid-operation discards held words. Release is synchronous to next clk edge.
//  - Per-output slot FSM, 2 states: EMPTY (out_valid[k]=0) / FULL (out_valid[k]=1).
//      load_k  = in_valid & in_ready & (in_sel==k)
//      drain_k = out_valid[k] & out_ready[k]
//      EMPTY --load_k--> FULL
//      FULL  --drain_k & !load_k--> EMPTY
//      FULL  --drain_k & load_k--> FULL, new word loaded (back-to-back, no bubble)
//      FULL  --!drain_k--> FULL, out_data_k held stable
//  - in_ready = !out_valid[in_sel] | out_ready[in_sel].
//    Pure function of current in_sel/out_valid/out_ready. No dependence on in_valid.
//  - Latency: word accepted at edge N appears on out_data_k with out_valid[k]=1 after edge N.
//    Full throughput: one word per cycle when the addressed consumer keeps ready=1.
//  - At most one load per cycle. Drains on all four outputs may occur in the same cycle,
//    independently and concurrently with a load to any slot.
//  - out_data_k retains its last value when the slot is EMPTY. Consumers must ignore it.
//  - out_cnt_k increments by 1 on each drain_k. Wraps 2^CNT_W-1 -> 0, no saturation.
//  - Upstream must hold in_data/in_sel stable while in_valid & !in_ready. The block does not
//    check this. A changed in_sel immediately re-evaluates in_ready.
//  - in_sel covers all 4 codes. No illegal select exists.
//  - Word order is preserved per output. No ordering is implied across outputs.
// TESTING (W=8, CNT_W=8)
//  1 Reset: rst_n=0 mid-stream, slots full -> out_valid=0, out_data*=0, out_cnt*=0 immediately,
//    without a clock edge.
//  2 Route: send 8'hA0..A3 with in_sel=0..3, all out_ready=0 -> out_valid=4'hF,
//    out_data0..3 = A0,A1,A2,A3.
//  3 Stall isolation: slot 2 full, out_ready=0 -> in_sel=2 gives in_ready=0;
//    in_sel=1 (slot 1 empty) gives in_ready=1 and the word loads.
//  4 Back-to-back: in_sel=3, out_ready[3]=1, in_valid=1 for 10 cycles, data 0..9 ->
//    in_ready stays 1, out_data3 = 0..9 one per cycle, out_cnt3=10.
//  5 Hold: slot 0 = 8'h5A, out_ready[0]=0 for 5 cycles -> out_data0 stays 5A, out_valid[0]=1;
//    then ready=1 for 1 cycle -> out_valid[0]=0, out_cnt0 += 1.
//  6 Wrap: 256 drains on output 1 -> out_cnt1 returns to 0. Random 2000-cycle run against
//    per-output queue model: every word delivered once, in order, to the correct output.

Source files
------------

// File: rtl/demux4s_stream.sv
`default_nettype none
// ============================================================================
// Module   : demux4s_stream
// Brief    : 1-to-4 stream demultiplexer into four single-entry output slots.
// Revision : 1.0 - initial release
// ============================================================================
module demux4s_stream #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W-1:0]     out_data0,
  output logic [W-1:0]     out_data1,
  output logic [W-1:0]     out_data2,
  output logic [W-1:0]     out_data3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [CNT_W-1:0] out_cnt0,
  output logic [CNT_W-1:0] out_cnt1,
  output logic [CNT_W-1:0] out_cnt2,
  output logic [CNT_W-1:0] out_cnt3
);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slot_state_t;

  logic [3:0]         w_full;
  logic [3:0]         w_load;
  logic [3:0]         w_drain;
  logic               w_in_ready;
  logic [4*W-1:0]     w_data;
  logic [4*CNT_W-1:0] w_cnt;

  // A full slot can still accept when its consumer drains in the same cycle.
  assign w_in_ready = ~w_full[in_sel] | out_ready[in_sel];
  assign in_ready   = w_in_ready;

  generate
    for (genvar k = 0; k < 4; k++) begin : g_slot
      localparam logic [1:0] c_SEL = 2'(k);

      slot_state_t      r_state;
      logic [W-1:0]     r_data;
      logic [CNT_W-1:0] r_cnt;

      assign w_full[k]  = (r_state == S_FULL);
      assign w_load[k]  = in_valid & w_in_ready & (in_sel == c_SEL);
      assign w_drain[k] = w_full[k] & out_ready[k];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_state <= S_EMPTY;
          r_data  <= '0;
          r_cnt   <= '0;
        end else begin
          case (r_state)
            S_EMPTY: begin
              if (w_load[k]) begin
                r_state <= S_FULL;
                r_data  <= in_data;
              end
            end
            S_FULL: begin
              if (w_load[k]) begin
                r_data <= in_data;
              end else if (w_drain[k]) begin
                r_state <= S_EMPTY;
              end
            end
            default: r_state <= S_EMPTY;
          endcase
          if (w_drain[k]) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      end

      assign w_data[k*W +: W]         = r_data;
      assign w_cnt[k*CNT_W +: CNT_W]  = r_cnt;
    end
  endgenerate

  assign out_valid = w_full;
  assign out_data0 = w_data[0*W +: W];
  assign out_data1 = w_data[1*W +: W];
  assign out_data2 = w_data[2*W +: W];
  assign out_data3 = w_data[3*W +: W];
  assign out_cnt0  = w_cnt[0*CNT_W +: CNT_W];
  assign out_cnt1  = w_cnt[1*CNT_W +: CNT_W];
  assign out_cnt2  = w_cnt[2*CNT_W +: CNT_W];
  assign out_cnt3  = w_cnt[3*CNT_W +: CNT_W];

endmodule
`default_nettype wire

// File: tb/tb_demux4s_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux4s_stream
// Brief    : Directed and scoreboarded bench for demux4s_stream (W=8, CNT_W=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux4s_stream;

  localparam int W     = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [W-1:0]     in_data;
  logic [1:0]       in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     out_data0, out_data1, out_data2, out_data3;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [CNT_W-1:0] out_cnt0, out_cnt1, out_cnt2, out_cnt3;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]     od [4];
  logic [CNT_W-1:0] oc [4];

  // Random-run scoreboard state
  logic [W-1:0] q [4][$];
  logic [3:0]   m_valid;
  int           drains [4];

  assign od[0] = out_data0;
  assign od[1] = out_data1;
  assign od[2] = out_data2;
  assign od[3] = out_data3;
  assign oc[0] = out_cnt0;
  assign oc[1] = out_cnt1;
  assign oc[2] = out_cnt2;
  assign oc[3] = out_cnt3;

  always #5 clk = ~clk;

  demux4s_stream #(.W(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cnt0  (out_cnt0),
    .out_cnt1  (out_cnt1),
    .out_cnt2  (out_cnt2),
    .out_cnt3  (out_cnt3)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_data   = '0;
    out_ready = 4'h0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 4'h0) begin
      errors++;
      $display("FAIL reset_valid: got %h expected 0", out_valid);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (od[k] !== 8'h00 || oc[k] !== 8'h00) begin
        errors++;
        $display("FAIL reset_out%0d: data %h cnt %h expected 00/00", k, od[k], oc[k]);
      end
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", in_ready);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_route();
    out_ready = 4'h0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_sel   = 2'(i);
      in_data  = 8'(8'hA0 + i);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL route_ready%0d: got %b expected 1", i, in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'hF) begin
      errors++;
      $display("FAIL route_valid: got %h expected F", out_valid);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (od[k] !== 8'(8'hA0 + k)) begin
        errors++;
        $display("FAIL route_data%0d: got %h expected %h", k, od[k], 8'(8'hA0 + k));
      end
    end
  endtask

  task automatic test_stall();
    out_ready = 4'b0010;
    tick();
    out_ready = 4'h0;
    checks++;
    if (out_valid !== 4'b1101 || oc[1] !== 8'd1) begin
      errors++;
      $display("FAIL stall_drain1: valid %b cnt1 %0d expected 1101/1", out_valid, oc[1]);
    end
    in_valid = 1'b1;
    in_sel   = 2'd2;
    in_data  = 8'h77;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_busy_ready: got %b expected 0", in_ready);
    end
    tick();
    checks++;
    if (od[2] !== 8'hA2 || out_valid !== 4'b1101) begin
      errors++;
      $display("FAIL stall_busy_hold: data2 %h valid %b expected A2/1101", od[2], out_valid);
    end
    in_sel  = 2'd1;
    in_data = 8'h55;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_free_ready: got %b expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'hF || od[1] !== 8'h55 || od[2] !== 8'hA2) begin
      errors++;
      $display("FAIL stall_free_load: valid %h d1 %h d2 %h expected F/55/A2", out_valid, od[1], od[2]);
    end
    out_ready = 4'hF;
    tick();
    out_ready = 4'h0;
    checks++;
    if (out_valid !== 4'h0 || oc[0] !== 8'd1 || oc[1] !== 8'd2 || oc[2] !== 8'd1 || oc[3] !== 8'd1) begin
      errors++;
      $display("FAIL stall_drain_all: valid %h cnt %0d %0d %0d %0d expected 0 / 1 2 1 1",
               out_valid, oc[0], oc[1], oc[2], oc[3]);
    end
  endtask

  task automatic test_back_to_back();
    in_sel    = 2'd3;
    out_ready = 4'b1000;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 8'(i);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready%0d: got %b expected 1", i, in_ready);
      end
      tick();
      checks++;
      if (od[3] !== 8'(i) || out_valid[3] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_data%0d: data %h valid %b expected %h/1", i, od[3], out_valid[3], 8'(i));
      end
    end
    in_valid = 1'b0;
    checks++;
    if (oc[3] !== 8'd10) begin
      errors++;
      $display("FAIL b2b_cnt_mid: got %0d expected 10", oc[3]);
    end
    tick();
    out_ready = 4'h0;
    checks++;
    if (out_valid[3] !== 1'b0 || oc[3] !== 8'd11) begin
      errors++;
      $display("FAIL b2b_cnt_end: valid %b cnt %0d expected 0/11", out_valid[3], oc[3]);
    end
  endtask

  task automatic test_hold();
    out_ready = 4'h0;
    in_sel    = 2'd0;
    in_data   = 8'h5A;
    in_valid  = 1'b1;
    tick();
    in_data = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_ready%0d: got %b expected 0", i, in_ready);
      end
      tick();
      checks++;
      if (od[0] !== 8'h5A || out_valid[0] !== 1'b1) begin
        errors++;
        $display("FAIL hold_data%0d: data %h valid %b expected 5A/1", i, od[0], out_valid[0]);
      end
    end
    in_valid  = 1'b0;
    out_ready = 4'b0001;
    tick();
    out_ready = 4'h0;
    checks++;
    if (out_valid[0] !== 1'b0 || oc[0] !== 8'd2 || od[0] !== 8'h5A) begin
      errors++;
      $display("FAIL hold_release: valid %b cnt %0d data %h expected 0/2/5A", out_valid[0], oc[0], od[0]);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 4'h0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_sel   = 2'(i);
      in_data  = 8'(8'hC0 + i);
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'hF) begin
      errors++;
      $display("FAIL areset_pre: valid %h expected F", out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 4'h0) begin
      errors++;
      $display("FAIL areset_valid: got %h expected 0", out_valid);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (od[k] !== 8'h00 || oc[k] !== 8'h00) begin
        errors++;
        $display("FAIL areset_out%0d: data %h cnt %h expected 00/00", k, od[k], oc[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_wrap();
    out_ready = 4'b0010;
    in_sel    = 2'd1;
    in_valid  = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_data = 8'(i);
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (oc[1] !== 8'hFF || od[1] !== 8'hFF) begin
      errors++;
      $display("FAIL wrap_pre: cnt %h data %h expected FF/FF", oc[1], od[1]);
    end
    tick();
    out_ready = 4'h0;
    checks++;
    if (oc[1] !== 8'h00 || out_valid !== 4'h0) begin
      errors++;
      $display("FAIL wrap_zero: cnt %h valid %h expected 00/0", oc[1], out_valid);
    end
  endtask

  task automatic random_cycle(input bit flush);
    logic         exp_rdy;
    logic [W-1:0] exp_d;
    if (flush) begin
      in_valid  = 1'b0;
      out_ready = 4'hF;
    end else begin
      in_valid  = 1'($urandom_range(0, 1));
      in_sel    = 2'($urandom_range(0, 3));
      in_data   = 8'($urandom);
      out_ready = 4'($urandom);
    end
    #1;
    exp_rdy = ~m_valid[in_sel] | out_ready[in_sel];
    checks++;
    if (in_ready !== exp_rdy) begin
      errors++;
      $display("FAIL rand_ready: got %b expected %b", in_ready, exp_rdy);
    end
    checks++;
    if (out_valid !== m_valid) begin
      errors++;
      $display("FAIL rand_valid: got %b expected %b", out_valid, m_valid);
    end
    for (int k = 0; k < 4; k++) begin
      if (m_valid[k] && out_ready[k]) begin
        checks++;
        if (q[k].size() == 0) begin
          errors++;
          $display("FAIL rand_order%0d: got %h expected no word", k, od[k]);
        end else begin
          exp_d = q[k].pop_front();
          if (od[k] !== exp_d) begin
            errors++;
            $display("FAIL rand_data%0d: got %h expected %h", k, od[k], exp_d);
          end
        end
        m_valid[k] = 1'b0;
        drains[k]++;
      end
    end
    if (in_valid && exp_rdy) begin
      q[in_sel].push_back(in_data);
      m_valid[in_sel] = 1'b1;
    end
    tick();
  endtask

  task automatic test_random();
    m_valid = 4'h0;
    for (int k = 0; k < 4; k++) begin
      drains[k] = 0;
      q[k].delete();
    end
    for (int i = 0; i < 2000; i++) random_cycle(1'b0);
    for (int i = 0; i < 2; i++) random_cycle(1'b1);
    out_ready = 4'h0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (q[k].size() != 0 || oc[k] !== 8'(drains[k])) begin
        errors++;
        $display("FAIL rand_end%0d: pending %0d cnt %0d expected 0/%0d",
                 k, q[k].size(), oc[k], 8'(drains[k]));
      end
    end
  endtask

  initial begin
    test_reset();
    test_route();
    test_stall();
    test_back_to_back();
    test_hold();
    test_async_reset();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
